axi4_lite_read_arbiter: RTL and testbench
=========================================

Name: axi4_lite_read_arbiter

Overview:
- Shares one AXI4-lite read port (AR + R channels) between two requesters: requester 0 (IFU instruction fetch) and requester 1 (LSU load).
- Sits between the core front/back end and the memory-side AXI4-lite read slave.
- Grants one requester at a time, owns the AR/R handshakes, and returns a registered, single-cycle response pulse to the granted requester.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req0_valid  in  1  IFU read request
req0_addr  in  ADDR_W  IFU address
req0_ready  out  1  IFU request accepted (1-cycle pulse)
rsp0_valid  out  1  IFU response valid (1-cycle pulse)
req1_valid  in  1  LSU read request
req1_addr  in  ADDR_W  LSU address
req1_ready  out  1  LSU request accepted (1-cycle pulse)
rsp1_valid  out  1  LSU response valid (1-cycle pulse)
rsp_data  out  DATA_W  response data, shared by both requesters, valid with rspN_valid
rsp_resp  out  2  AXI RRESP, valid with rspN_valid
araddr  out  ADDR_W  AR address
arvalid  out  1  AR valid
arprot  out  3  constant 3'b000
arready  in  1  AR ready
rdata  in  DATA_W  R data
rresp  in  2  R response
rvalid  in  1  R valid
rready  out  1  R ready

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - State goes to IDLE.
  - All outputs are 0: arvalid, rready, reqN_ready, rspN_valid, araddr, rsp_data, rsp_resp.
  - Round-robin pointer goes to 0.
- States: IDLE, AR, R, RSP. Encoding is 2 bits.
- IDLE:
  - If any reqN_valid=1, select the winner by priority.
  - Pulse the winner's reqN_ready for that cycle only.
  - Latch araddr <= winner address and latch the grant id.
  - Next state is AR, with arvalid=1 on the next cycle.
- AR:
  - arvalid is held at 1 and araddr is held stable until arvalid&arready.
  - arvalid never depends combinationally on arready.
  - On the handshake, arvalid <= 0 and the state moves to R.
- R:
  - rready=1 throughout the state.
  - On rvalid: capture rdata/rresp into rsp_data/rsp_resp, clear rready, and move to RSP.
- RSP:
  - rspN_valid=1 for exactly one cycle, for the granted id only.
  - Next state is IDLE.
- Minimum latency is 4 cycles, measured from request accept in IDLE to the rsp pulse, with arready and rvalid asserted immediately.
- Requesters hold reqN_valid/addr until they see reqN_ready. Deasserting early is the requester's error; the arbiter ignores it.
- Only one transaction is outstanding; requests arriving outside IDLE wait.
- Simultaneous req0/req1 in IDLE: resolved by the priority rule below.
- Non-OKAY rresp is passed through unmodified; the arbiter takes no retry action.
- Reset mid-transaction aborts immediately, with no response pulse. The slave-side protocol is the system's responsibility, since reset is global.
- rsp_data/rsp_resp hold their last value outside RSP.

Optional Feature:
- Macro: AXI_ARB_ROUND_ROBIN_EN.
- Defined:
  - Round-robin arbitration: on a tie, grant the requester not granted last.
  - The pointer updates at each grant.
- Undefined:
  - Fixed priority: LSU (req1) always wins a tie over IFU (req0).
  - No pointer register.

Decomposition:
- Shared package/header (axi4_lite_defs.vh) holds:
  - State localparams ST_IDLE=2'd0, ST_AR=2'd1, ST_R=2'd2, ST_RSP=2'd3.
  - RESP codes OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - ARPROT default 3'b000.
- Sub-module arb2_grant: 2-input combinational/pointer grant logic. It isolates the round-robin vs fixed-priority selection behind the macro.

Test Plan:
- Single IFU read:
  - Stimulus: req0_addr=0x8000_0000, arready=1, slave returns rdata=0x0000_0013_0000_0093, rresp=0 one cycle after the AR handshake.
  - Required: req0_ready pulses once; rsp0_valid pulses once with that data, 4 cycles after accept; rsp1_valid stays 0.
- Simultaneous requests:
  - Stimulus: req0 (0x8000_0000) and req1 (0x8000_1000) both asserted.
  - Required, fixed priority: LSU first, then IFU.
  - Required, round-robin: grants alternate across 4 back-to-back ties (1,0,1,0 when the last grant was 0).
- AR backpressure:
  - Stimulus: arready=0 for 5 cycles.
  - Required: arvalid=1 and araddr constant for all 5 cycles; a single AR handshake; no second request accepted meanwhile.
- R backpressure:
  - Stimulus: rvalid delayed 7 cycles.
  - Required: rready=1 throughout; response data captured only on rvalid.
- Error response:
  - Stimulus: rresp=2'b10 (SLVERR) on an LSU read.
  - Required: rsp1_valid pulses with rsp_resp=2'b10; the arbiter returns to IDLE and serves the next request normally.
- Reset mid-op:
  - Stimulus: rst_n=0 while in state R.
  - Required: next cycle all outputs are 0, state is IDLE, and no rsp pulse is emitted.

Source files
------------

// File: rtl/axi4_lite_read_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// axi4_lite_read_arbiter_pkg
//   Shared definitions for the two-requester AXI4-lite read arbiter:
//   FSM state encodings, AXI RRESP codes and the default ARPROT value.
// ---------------------------------------------------------------------------
package axi4_lite_read_arbiter_pkg;

  // Arbiter FSM states (2-bit encoding)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_AR   = 2'd1;
  localparam logic [1:0] ST_R    = 2'd2;
  localparam logic [1:0] ST_RSP  = 2'd3;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Unprivileged, secure, data access
  localparam logic [2:0] ARPROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axi4_lite_read_arbiter_arb2_grant.sv
// ---------------------------------------------------------------------------
// arb2_grant
//   Two-input grant selection for the AXI4-lite read arbiter.
//   Build option: AXI_ARB_ROUND_ROBIN_EN
//     defined   - round-robin: on a tie, grant the requester not granted last;
//                 the pointer records the id of every grant taken.
//     undefined - fixed priority: req1 (LSU) wins every tie; no state.
//
// Ports:
//   clk, rst_n   clock / synchronous active-low reset (round-robin build only)
//   advance      a grant is being taken this cycle (round-robin build only)
//   req0, req1   request lines
//   grant_valid  at least one request is present
//   grant_id     selected requester (0 = req0, 1 = req1)
// ---------------------------------------------------------------------------
module arb2_grant
  import axi4_lite_read_arbiter_pkg::*;
(
`ifdef AXI_ARB_ROUND_ROBIN_EN
  input  logic clk,
  input  logic rst_n,
  input  logic advance,
`endif
  input  logic req0,
  input  logic req1,
  output logic grant_valid,
  output logic grant_id
);

  assign grant_valid = req0 | req1;

`ifdef AXI_ARB_ROUND_ROBIN_EN
  logic last_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_reg <= 1'b0;
    end else if (advance) begin
      last_reg <= grant_id;
    end
  end

  // A lone requester always wins; a tie goes to the one not served last.
  always_comb begin
    grant_id = req1;
    if (req0 && req1) begin
      grant_id = ~last_reg;
    end
  end
`else
  // LSU wins ties: whenever req1 is present it is selected.
  assign grant_id = req1;
`endif

endmodule

// File: rtl/axi4_lite_read_arbiter.sv
// ---------------------------------------------------------------------------
// axi4_lite_read_arbiter
//   Shares one AXI4-lite read port (AR + R) between requester 0 (IFU) and
//   requester 1 (LSU). One transaction outstanding at a time:
//     IDLE -> AR -> R -> RSP -> IDLE
//   Build option: AXI_ARB_ROUND_ROBIN_EN selects round-robin tie breaking
//   (default: LSU wins ties). See arb2_grant.
//
// Ports:
//   clk, rst_n                 clock / synchronous active-low reset
//   req0_valid/addr/ready      IFU request; ready is a 1-cycle accept pulse
//   rsp0_valid                 IFU response pulse
//   req1_valid/addr/ready      LSU request; ready is a 1-cycle accept pulse
//   rsp1_valid                 LSU response pulse
//   rsp_data, rsp_resp         shared response payload, held between responses
//   araddr/arvalid/arprot/arready   AXI AR channel (master side)
//   rdata/rresp/rvalid/rready       AXI R channel (master side)
// ---------------------------------------------------------------------------
module axi4_lite_read_arbiter
  import axi4_lite_read_arbiter_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              rsp0_valid,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_resp,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  output logic [2:0]        arprot,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready
);

  logic [1:0]        state_reg;
  logic              grant_id_reg;
  logic [ADDR_W-1:0] araddr_reg;
  logic              arvalid_reg;
  logic              rready_reg;
  logic [DATA_W-1:0] rsp_data_reg;
  logic [1:0]        rsp_resp_reg;
  logic              rsp0_valid_reg;
  logic              rsp1_valid_reg;

  logic win_valid;
  logic win_id;
  logic accept;

  // Accept only in IDLE; rst_n gating keeps the ready pulses low while the
  // block is held in reset even if a requester is already asserting valid.
  assign accept = rst_n && (state_reg == ST_IDLE) && win_valid;

  arb2_grant u_grant (
`ifdef AXI_ARB_ROUND_ROBIN_EN
    .clk         (clk),
    .rst_n       (rst_n),
    .advance     (accept),
`endif
    .req0        (req0_valid),
    .req1        (req1_valid),
    .grant_valid (win_valid),
    .grant_id    (win_id)
  );

  assign req0_ready = accept && !win_id;
  assign req1_ready = accept &&  win_id;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      grant_id_reg   <= 1'b0;
      araddr_reg     <= '0;
      arvalid_reg    <= 1'b0;
      rready_reg     <= 1'b0;
      rsp_data_reg   <= '0;
      rsp_resp_reg   <= RESP_OKAY;
      rsp0_valid_reg <= 1'b0;
      rsp1_valid_reg <= 1'b0;
    end else begin
      // Response pulses last exactly one cycle (the RSP state).
      rsp0_valid_reg <= 1'b0;
      rsp1_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            araddr_reg   <= win_id ? req1_addr : req0_addr;
            grant_id_reg <= win_id;
            arvalid_reg  <= 1'b1;
            state_reg    <= ST_AR;
          end
        end
        ST_AR: begin
          // arvalid is a register, so it never depends on arready in-cycle.
          if (arready) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            state_reg   <= ST_R;
          end
        end
        ST_R: begin
          if (rvalid) begin
            rsp_data_reg   <= rdata;
            rsp_resp_reg   <= rresp;
            rready_reg     <= 1'b0;
            rsp0_valid_reg <= !grant_id_reg;
            rsp1_valid_reg <=  grant_id_reg;
            state_reg      <= ST_RSP;
          end
        end
        ST_RSP: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign araddr     = araddr_reg;
  assign arvalid    = arvalid_reg;
  assign arprot     = ARPROT_DEFAULT;
  assign rready     = rready_reg;
  assign rsp_data   = rsp_data_reg;
  assign rsp_resp   = rsp_resp_reg;
  assign rsp0_valid = rsp0_valid_reg;
  assign rsp1_valid = rsp1_valid_reg;

endmodule

// File: tb/tb_axi4_lite_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_read_arbiter
//   Directed bench for axi4_lite_read_arbiter. Background processes model the
//   two requesters (queues of addresses), a configurable AXI read slave and a
//   monitor that logs accepts, AR handshakes and response pulses. Each test
//   task drives a scenario and compares the logs against hand-derived values.
//   Expected tie-break order follows AXI_ARB_ROUND_ROBIN_EN when defined.
// ---------------------------------------------------------------------------
module tb_axi4_lite_read_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid;
  logic [63:0] req0_addr;
  logic        req0_ready;
  logic        rsp0_valid;
  logic        req1_valid;
  logic [63:0] req1_addr;
  logic        req1_ready;
  logic        rsp1_valid;
  logic [63:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic [63:0] araddr;
  logic        arvalid;
  logic [2:0]  arprot;
  logic        arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  axi4_lite_read_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_ready (req0_ready),
    .rsp0_valid (rsp0_valid),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_ready (req1_ready),
    .rsp1_valid (rsp1_valid),
    .rsp_data   (rsp_data),
    .rsp_resp   (rsp_resp),
    .araddr     (araddr),
    .arvalid    (arvalid),
    .arprot     (arprot),
    .arready    (arready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- requester models ----------------
  logic [63:0] q0[$];
  logic [63:0] q1[$];

  initial begin : requester0
    bit acc;
    acc = 1'b0;
    req0_valid = 1'b0;
    req0_addr  = '0;
    forever begin
      @(negedge clk);
      if (req0_valid && acc) begin
        req0_valid = 1'b0;
        acc = 1'b0;
        void'(q0.pop_front());
      end
      if (!req0_valid && q0.size() > 0) begin
        req0_valid = 1'b1;
        req0_addr  = q0[0];
      end
      #1;
      if (req0_valid && req0_ready) acc = 1'b1;
    end
  end

  initial begin : requester1
    bit acc;
    acc = 1'b0;
    req1_valid = 1'b0;
    req1_addr  = '0;
    forever begin
      @(negedge clk);
      if (req1_valid && acc) begin
        req1_valid = 1'b0;
        acc = 1'b0;
        void'(q1.pop_front());
      end
      if (!req1_valid && q1.size() > 0) begin
        req1_valid = 1'b1;
        req1_addr  = q1[0];
      end
      #1;
      if (req1_valid && req1_ready) acc = 1'b1;
    end
  end

  // ---------------- AXI read slave model ----------------
  // arready rises after ar_wait stalled AR cycles; rvalid rises after r_wait
  // stalled R cycles. rdata/rresp carry junk whenever rvalid is low.
  int          ar_wait  = 0;
  int          r_wait   = 0;
  logic [63:0] slv_data = '0;
  logic [1:0]  slv_resp = '0;
  localparam logic [63:0] JUNK = 64'hDEAD_BEEF_DEAD_BEEF;

  initial begin : slave
    int ar_cnt, r_cnt;
    bit ar_fire, r_fire, r_pend;
    ar_cnt = 0; r_cnt = 0; ar_fire = 0; r_fire = 0; r_pend = 0;
    arready = 1'b0; rvalid = 1'b0; rdata = JUNK; rresp = 2'b11;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        arready = 1'b0; rvalid = 1'b0; rdata = JUNK; rresp = 2'b11;
        ar_fire = 0; r_fire = 0; r_pend = 0; ar_cnt = 0; r_cnt = 0;
      end else begin
        if (r_fire) begin
          rvalid = 1'b0; r_pend = 0; rdata = JUNK; rresp = 2'b11;
        end
        if (ar_fire) begin
          r_pend = 1; r_cnt = 0;
        end
        if (arvalid) begin
          if (ar_cnt >= ar_wait) arready = 1'b1;
          else begin arready = 1'b0; ar_cnt++; end
        end else begin
          arready = 1'b0; ar_cnt = 0;
        end
        if (r_pend && !rvalid) begin
          if (r_cnt >= r_wait) begin
            rvalid = 1'b1; rdata = slv_data; rresp = slv_resp;
          end else begin
            r_cnt++;
          end
        end
        ar_fire = arvalid && arready;
        r_fire  = rvalid && rready;
      end
    end
  end

  // ---------------- monitor ----------------
  int          acc_id_q[$];
  int          acc_cyc_q[$];
  int          rsp_id_q[$];
  int          rsp_cyc_q[$];
  logic [63:0] rsp_data_q[$];
  logic [1:0]  rsp_resp_q[$];
  logic [63:0] ar_addr_q[$];
  int          rready_cnt = 0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      #2;
      if (req0_ready) begin acc_id_q.push_back(0); acc_cyc_q.push_back(cyc); end
      if (req1_ready) begin acc_id_q.push_back(1); acc_cyc_q.push_back(cyc); end
      if (arvalid && arready) ar_addr_q.push_back(araddr);
      if (rready) rready_cnt++;
      if (rsp0_valid) begin
        rsp_id_q.push_back(0); rsp_cyc_q.push_back(cyc);
        rsp_data_q.push_back(rsp_data); rsp_resp_q.push_back(rsp_resp);
        $display("txn: rsp id=0 data=%h resp=%0d cyc=%0d", rsp_data, rsp_resp, cyc);
      end
      if (rsp1_valid) begin
        rsp_id_q.push_back(1); rsp_cyc_q.push_back(cyc);
        rsp_data_q.push_back(rsp_data); rsp_resp_q.push_back(rsp_resp);
        $display("txn: rsp id=1 data=%h resp=%0d cyc=%0d", rsp_data, rsp_resp, cyc);
      end
    end
  end

  task automatic clear_logs();
    acc_id_q.delete(); acc_cyc_q.delete();
    rsp_id_q.delete(); rsp_cyc_q.delete();
    rsp_data_q.delete(); rsp_resp_q.delete();
    ar_addr_q.delete();
    rready_cnt = 0;
  endtask

  // Waits (bounded) for n logged responses, then lets the bus settle.
  task automatic wait_rsps(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (rsp_id_q.size() < n && k < budget) begin
      @(negedge clk); #3; k++;
    end
    ok = (rsp_id_q.size() >= n);
    repeat (3) begin @(negedge clk); #3; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    checks++;
    if (arvalid !== 1'b0 || rready !== 1'b0) begin
      errors++; $display("FAIL reset_handshake: arvalid=%b rready=%b, need 0 0", arvalid, rready);
    end
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: r0=%b r1=%b s0=%b s1=%b, need 0", req0_ready, req1_ready, rsp0_valid, rsp1_valid);
    end
    checks++;
    if (araddr !== 64'h0 || rsp_data !== 64'h0 || rsp_resp !== 2'b00) begin
      errors++; $display("FAIL reset_data: araddr=%h rsp_data=%h rsp_resp=%b, need 0", araddr, rsp_data, rsp_resp);
    end
    checks++;
    if (arprot !== 3'b000) begin
      errors++; $display("FAIL reset_arprot: got %b need 000", arprot);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_ifu();
    bit ok;
    clear_logs();
    ar_wait = 0; r_wait = 0;
    slv_data = 64'h0000_0013_0000_0093; slv_resp = 2'b00;
    q0.push_back(64'h8000_0000);
    wait_rsps(1, 50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout: responses=%0d need 1", rsp_id_q.size()); end
    checks++;
    if (acc_id_q.size() != 1 || acc_id_q[0] != 0) begin
      errors++; $display("FAIL single_accept: accepts=%0d first_id=%0d, need 1 accept of id 0", acc_id_q.size(), acc_id_q.size() ? acc_id_q[0] : -1);
    end
    checks++;
    if (rsp_id_q.size() != 1 || rsp_id_q[0] != 0) begin
      errors++; $display("FAIL single_rsp_id: pulses=%0d first_id=%0d, need 1 pulse on id 0", rsp_id_q.size(), rsp_id_q.size() ? rsp_id_q[0] : -1);
    end
    // Accept cycle (IDLE) .. pulse cycle (RSP) span IDLE,AR,R,RSP: 4 cycles.
    checks++;
    if (rsp_cyc_q.size() < 1 || acc_cyc_q.size() < 1 || rsp_cyc_q[0] - acc_cyc_q[0] != 3) begin
      errors++; $display("FAIL single_latency: rsp-accept edges=%0d, need 3 (4-cycle window)", (rsp_cyc_q.size() && acc_cyc_q.size()) ? rsp_cyc_q[0] - acc_cyc_q[0] : -1);
    end
    checks++;
    if (rsp_data_q.size() < 1 || rsp_data_q[0] !== 64'h0000_0013_0000_0093 || rsp_resp_q[0] !== 2'b00) begin
      errors++; $display("FAIL single_data: data=%h resp=%b, need 0000001300000093 00", rsp_data_q.size() ? rsp_data_q[0] : 64'hx, rsp_resp_q.size() ? rsp_resp_q[0] : 2'bx);
    end
    checks++;
    if (ar_addr_q.size() != 1 || ar_addr_q[0] !== 64'h8000_0000) begin
      errors++; $display("FAIL single_ar: handshakes=%0d addr=%h, need 1 at 80000000", ar_addr_q.size(), ar_addr_q.size() ? ar_addr_q[0] : 64'hx);
    end
  endtask

  task automatic test_tie();
    bit ok;
    clear_logs();
    slv_data = 64'h0000_0000_CAFE_0001; slv_resp = 2'b00;
    q0.push_back(64'h8000_0000);
    q1.push_back(64'h8000_1000);
    wait_rsps(2, 80, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL tie_timeout: responses=%0d need 2", rsp_id_q.size()); end
    checks++;
    if (acc_id_q.size() != 2 || acc_id_q[0] != 1 || acc_id_q[1] != 0) begin
      errors++; $display("FAIL tie_order: accepts=%0d ids=%0d,%0d need 1,0", acc_id_q.size(), acc_id_q.size() > 0 ? acc_id_q[0] : -1, acc_id_q.size() > 1 ? acc_id_q[1] : -1);
    end
    checks++;
    if (ar_addr_q.size() != 2 || ar_addr_q[0] !== 64'h8000_1000 || ar_addr_q[1] !== 64'h8000_0000) begin
      errors++; $display("FAIL tie_araddr: n=%0d first=%h, need 80001000 then 80000000", ar_addr_q.size(), ar_addr_q.size() ? ar_addr_q[0] : 64'hx);
    end
    checks++;
    if (rsp_id_q.size() != 2 || rsp_id_q[0] != 1 || rsp_id_q[1] != 0) begin
      errors++; $display("FAIL tie_rsp_order: n=%0d, need responses 1 then 0", rsp_id_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int exp_ids[4];
`ifdef AXI_ARB_ROUND_ROBIN_EN
    exp_ids[0] = 1; exp_ids[1] = 0; exp_ids[2] = 1; exp_ids[3] = 0;
`else
    exp_ids[0] = 1; exp_ids[1] = 1; exp_ids[2] = 0; exp_ids[3] = 0;
`endif
    clear_logs();
    q0.push_back(64'h8000_0000); q0.push_back(64'h8000_0008);
    q1.push_back(64'h8000_1000); q1.push_back(64'h8000_1008);
    wait_rsps(4, 120, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_timeout: responses=%0d need 4", rsp_id_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (acc_id_q.size() <= i || acc_id_q[i] != exp_ids[i]) begin
        errors++; $display("FAIL b2b_grant%0d: got %0d need %0d", i, acc_id_q.size() > i ? acc_id_q[i] : -1, exp_ids[i]);
      end
    end
    checks++;
    if (acc_cyc_q.size() != 4 || acc_cyc_q[3] - acc_cyc_q[0] != 12) begin
      errors++; $display("FAIL b2b_spacing: accepts=%0d span=%0d, need 4 accepts spanning 12 edges", acc_cyc_q.size(), acc_cyc_q.size() == 4 ? acc_cyc_q[3] - acc_cyc_q[0] : -1);
    end
  endtask

  task automatic test_ar_backpressure();
    bit ok;
    int k;
    clear_logs();
    ar_wait = 5; r_wait = 0;
    slv_data = 64'h0000_0000_0000_0AAA; slv_resp = 2'b00;
    q0.push_back(64'h8000_2000);
    k = 0;
    while (acc_id_q.size() == 0 && k < 20) begin @(negedge clk); #3; k++; end
    q1.push_back(64'h8000_3000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #3;
      checks++;
      if (arvalid !== 1'b1 || araddr !== 64'h8000_2000 || acc_id_q.size() != 1) begin
        errors++; $display("FAIL arbp_stall%0d: arvalid=%b araddr=%h accepts=%0d, need 1 80002000 1", i, arvalid, araddr, acc_id_q.size());
      end
    end
    wait_rsps(2, 80, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL arbp_timeout: responses=%0d need 2", rsp_id_q.size()); end
    checks++;
    if (ar_addr_q.size() != 2 || ar_addr_q[0] !== 64'h8000_2000) begin
      errors++; $display("FAIL arbp_handshakes: n=%0d first=%h, need 2 with first 80002000", ar_addr_q.size(), ar_addr_q.size() ? ar_addr_q[0] : 64'hx);
    end
    checks++;
    if (rsp_cyc_q.size() < 1 || acc_cyc_q.size() < 1 || rsp_cyc_q[0] - acc_cyc_q[0] != 8) begin
      errors++; $display("FAIL arbp_latency: got %0d need 8", (rsp_cyc_q.size() && acc_cyc_q.size()) ? rsp_cyc_q[0] - acc_cyc_q[0] : -1);
    end
    ar_wait = 0;
  endtask

  task automatic test_r_backpressure();
    bit ok;
    clear_logs();
    ar_wait = 0; r_wait = 7;
    slv_data = 64'h1122_3344_5566_7788; slv_resp = 2'b00;
    q0.push_back(64'h8000_4000);
    wait_rsps(1, 60, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rbp_timeout: responses=%0d need 1", rsp_id_q.size()); end
    checks++;
    if (rready_cnt != 8) begin
      errors++; $display("FAIL rbp_rready: rready cycles=%0d need 8", rready_cnt);
    end
    checks++;
    if (rsp_data_q.size() < 1 || rsp_data_q[0] !== 64'h1122_3344_5566_7788) begin
      errors++; $display("FAIL rbp_data: got %h need 1122334455667788", rsp_data_q.size() ? rsp_data_q[0] : 64'hx);
    end
    checks++;
    if (rsp_cyc_q.size() < 1 || acc_cyc_q.size() < 1 || rsp_cyc_q[0] - acc_cyc_q[0] != 10) begin
      errors++; $display("FAIL rbp_latency: got %0d need 10", (rsp_cyc_q.size() && acc_cyc_q.size()) ? rsp_cyc_q[0] - acc_cyc_q[0] : -1);
    end
    // Payload must be held after the pulse while rdata carries junk.
    checks++;
    if (rsp_data !== 64'h1122_3344_5566_7788 || rsp0_valid !== 1'b0) begin
      errors++; $display("FAIL rbp_hold: rsp_data=%h rsp0_valid=%b, need 1122334455667788 0", rsp_data, rsp0_valid);
    end
    r_wait = 0;
  endtask

  task automatic test_error_resp();
    bit ok;
    clear_logs();
    slv_data = 64'hBAD0_BAD0_BAD0_BAD0; slv_resp = 2'b10;
    q1.push_back(64'h8000_5000);
    wait_rsps(1, 50, ok);
    checks++;
    if (rsp_id_q.size() != 1 || rsp_id_q[0] != 1 || rsp_resp_q[0] !== 2'b10) begin
      errors++; $display("FAIL err_slverr: n=%0d id=%0d resp=%b, need 1 pulse id 1 resp 10", rsp_id_q.size(), rsp_id_q.size() ? rsp_id_q[0] : -1, rsp_resp_q.size() ? rsp_resp_q[0] : 2'bx);
    end
    slv_data = 64'h0000_0000_0000_0B0B; slv_resp = 2'b00;
    q0.push_back(64'h8000_5008);
    wait_rsps(2, 50, ok);
    checks++;
    if (rsp_id_q.size() != 2 || rsp_id_q[1] != 0 || rsp_resp_q[1] !== 2'b00 || rsp_data_q[1] !== 64'h0000_0000_0000_0B0B) begin
      errors++; $display("FAIL err_recover: n=%0d resp=%b data=%h, need second id 0 resp 00 data 0b0b", rsp_id_q.size(), rsp_resp_q.size() > 1 ? rsp_resp_q[1] : 2'bx, rsp_data_q.size() > 1 ? rsp_data_q[1] : 64'hx);
    end
  endtask

  task automatic test_reset_midop();
    bit ok;
    int k;
    clear_logs();
    ar_wait = 0; r_wait = 30;
    slv_data = 64'h0000_0000_0000_0777; slv_resp = 2'b00;
    q0.push_back(64'h8000_6000);
    k = 0;
    while (rready !== 1'b1 && k < 30) begin @(negedge clk); #3; k++; end
    checks++;
    if (rready !== 1'b1) begin errors++; $display("FAIL midrst_reach_r: rready=%b need 1", rready); end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); #3;
    checks++;
    if (arvalid !== 1'b0 || rready !== 1'b0 || araddr !== 64'h0) begin
      errors++; $display("FAIL midrst_bus: arvalid=%b rready=%b araddr=%h, need 0", arvalid, rready, araddr);
    end
    checks++;
    if (rsp_data !== 64'h0 || rsp_resp !== 2'b00 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || req0_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_rsp: data=%h resp=%b s0=%b s1=%b r0=%b, need 0", rsp_data, rsp_resp, rsp0_valid, rsp1_valid, req0_ready);
    end
    rst_n = 1'b1;
    r_wait = 0;
    repeat (40) @(negedge clk);
    #3;
    checks++;
    if (rsp_id_q.size() != 0) begin
      errors++; $display("FAIL midrst_no_pulse: pulses=%0d need 0", rsp_id_q.size());
    end
    // From IDLE the next request must see the full 4-cycle path.
    clear_logs();
    slv_data = 64'h0000_0000_0000_0888;
    q1.push_back(64'h8000_7000);
    wait_rsps(1, 50, ok);
    checks++;
    if (!ok || rsp_id_q[0] != 1 || acc_cyc_q.size() != 1 || rsp_cyc_q[0] - acc_cyc_q[0] != 3 || rsp_data_q[0] !== 64'h888) begin
      errors++; $display("FAIL midrst_resume: n=%0d, need one id-1 response 3 edges after accept with data 888", rsp_id_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_single_ifu();
    test_tie();
    test_back_to_back();
    test_ar_backpressure();
    test_r_backpressure();
    test_error_resp();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
